uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that merges N byte streams onto one UART TX port.
// A grant is held for a packet, capped by a burst limit and an idle timeout.
module uart_tx_arb #(
   parameter int N_REQ        = 4,
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [8*N_REQ-1:0]         req_data,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy
);

   localparam int GW = $clog2(N_REQ);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_e;

   state_e        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]    byte_cnt_q, byte_cnt_d;
   logic [9:0]    idle_cnt_q, idle_cnt_d;

   logic [GW-1:0] pick;
   logic [GW-1:0] grant_inc;
   logic          g_valid;
   logic          g_last;
   logic          xfer;
   logic          rel;

   // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
   always_comb begin : rr_pick
      logic [GW:0]   sum;
      logic [GW-1:0] idx;
      logic          found;
      pick  = rr_ptr_q;
      sum   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
         if (sum >= (GW+1)'(N_REQ)) begin
            sum = sum - (GW+1)'(N_REQ);
         end
         idx = sum[GW-1:0];
         if (!found && req_valid[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   assign g_valid   = req_valid[grant_q];
   assign g_last    = req_last[grant_q];
   assign xfer      = (state_q == S_LOCKED) && g_valid && tx_ready;
   assign grant_inc = (grant_q == GW'(N_REQ-1)) ? '0 : grant_q + GW'(1);
   assign grant_id  = grant_q;

   always_comb begin : out_mux
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      req_ready = '0;
      busy      = 1'b0;
      if (state_q == S_LOCKED) begin
         busy     = 1'b1;
         tx_valid = g_valid;
         for (int i = 0; i < N_REQ; i++) begin
            if (GW'(i) == grant_q) begin
               tx_data      = req_data[8*i +: 8];
               req_ready[i] = tx_ready;
            end
         end
      end
   end

   always_comb begin : next_state
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      byte_cnt_d = byte_cnt_q;
      idle_cnt_d = idle_cnt_q;
      rel        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (|req_valid) begin
               grant_d    = pick;
               byte_cnt_d = '0;
               idle_cnt_d = '0;
               state_d    = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (xfer) begin
               byte_cnt_d = byte_cnt_q + 8'd1;
               idle_cnt_d = '0;
               if (g_last || (byte_cnt_q + 8'd1 == 8'(MAX_BURST))) begin
                  rel = 1'b1;
               end
            end else if (g_valid) begin
               // stalled by tx_ready: the stream is alive, not idle
               idle_cnt_d = '0;
            end else if (idle_cnt_q == 10'(IDLE_TIMEOUT-1)) begin
               rel = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + 10'd1;
            end
            if (rel) begin
               state_d  = S_IDLE;
               rr_ptr_d = grant_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         byte_cnt_q <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_uart_tx_arb;

   localparam int N    = 4;
   localparam int MAXB = 4;
   localparam int IDLT = 8;
   localparam int CAP  = 512;

   logic            clk;
   logic            rst_n;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic [1:0]      grant_id;
   logic            busy;

   uart_tx_arb #(
      .N_REQ(N),
      .MAX_BURST(MAXB),
      .IDLE_TIMEOUT(IDLT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_data(req_data),
      .req_valid(req_valid),
      .req_last(req_last),
      .req_ready(req_ready),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .grant_id(grant_id),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // per-requester byte streams: {last, data}
   logic [8:0] src [N][CAP];
   int         head [N];
   int         tail [N];
   int         obs_idx [N];
   bit         gate [N];
   bit         tr;

   // model: owner (-1 when idle), last owner, round-robin start,
   // bytes sent this grant, consecutive valid-low cycles this grant
   int m_owner, m_last, m_rr, m_cnt, m_low;

   int n_chk, n_err, cyc;
   int nlog;
   int lg_cyc [1024];
   int lg_id  [1024];
   int lg_dt  [1024];
   int exp_id [16];
   int exp_dt [16];

   logic       obs_tv, obs_busy;
   logic [7:0] obs_td;
   logic [1:0] obs_gid;
   logic [3:0] obs_rdy;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic push(input int r, input logic [7:0] b, input bit last);
      if (tail[r] < CAP) begin
         src[r][tail[r]] = {last, b};
         tail[r]++;
      end
   endtask

   task automatic clear_streams();
      for (int i = 0; i < N; i++) begin
         head[i]    = 0;
         tail[i]    = 0;
         obs_idx[i] = 0;
         gate[i]    = 1'b1;
      end
      nlog = 0;
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 0;
      m_rr    = 0;
      m_cnt   = 0;
      m_low   = 0;
   endtask

   task automatic model_release(input int o);
      m_owner = -1;
      m_rr    = (o + 1) % N;
   endtask

   // one clock cycle: drive, compare against model, advance model
   task automatic step();
      logic [3:0] v;
      logic [7:0] dd [N];
      logic       ll [N];
      logic       e_busy, e_tv;
      logic [7:0] e_td;
      logic [3:0] e_rdy;
      int         o, g, k;
      bit         lastb;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         v[i]  = gate[i] && (head[i] < tail[i]);
         dd[i] = 8'h00;
         ll[i] = 1'b0;
         if (v[i]) begin
            dd[i] = src[i][head[i]][7:0];
            ll[i] = src[i][head[i]][8];
         end
         req_data[8*i +: 8] = dd[i];
         req_last[i]        = ll[i];
      end
      req_valid = v;
      tx_ready  = tr;
      #1;
      cyc++;
      e_busy = (m_owner >= 0);
      e_tv   = e_busy && v[m_owner];
      e_td   = e_busy ? dd[m_owner] : 8'h00;
      e_rdy  = (e_busy && tr) ? 4'(1 << m_owner) : 4'h0;
      chk("busy", 32'(busy), 32'(e_busy));
      chk("grant_id", 32'(grant_id), 32'(m_last));
      chk("tx_valid", 32'(tx_valid), 32'(e_tv));
      chk("tx_data", 32'(tx_data), 32'(e_td));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      obs_tv   = tx_valid;
      obs_td   = tx_data;
      obs_busy = busy;
      obs_gid  = grant_id;
      obs_rdy  = req_ready;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         g = int'(grant_id);
         if (obs_idx[g] < tail[g]) begin
            chk("stream_order", 32'(tx_data), 32'(src[g][obs_idx[g]][7:0]));
         end else begin
            chk("stream_extra", 32'(obs_idx[g]), 32'(tail[g] - 1));
         end
         obs_idx[g]++;
         if (nlog < 1024) begin
            lg_cyc[nlog] = cyc;
            lg_id[nlog]  = g;
            lg_dt[nlog]  = int'(tx_data);
            nlog++;
         end
      end
      if (m_owner < 0) begin
         for (int j = 0; j < N; j++) begin
            k = (m_rr + j) % N;
            if (m_owner < 0 && v[k]) begin
               m_owner = k;
               m_last  = k;
               m_cnt   = 0;
               m_low   = 0;
            end
         end
      end else begin
         o = m_owner;
         if (v[o] && tr) begin
            lastb = src[o][head[o]][8];
            head[o]++;
            m_cnt++;
            m_low = 0;
            if (lastb || m_cnt == MAXB) model_release(o);
         end else if (v[o]) begin
            m_low = 0;
         end else begin
            m_low++;
            if (m_low == IDLT) model_release(o);
         end
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_tx_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
      chk({tag, "_rst_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_rst_grant"}, 32'(grant_id), 32'd0);
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      model_reset();
      clear_streams();
      repeat (2) begin
         @(negedge clk);
         chk({tag, "_rst_hold_tx_valid"}, 32'(tx_valid), 32'd0);
      end
      rst_n = 1'b1;
   endtask

   task automatic set_exp(input int i, input int id, input int dt);
      exp_id[i] = id;
      exp_dt[i] = dt;
   endtask

   task automatic cmp_log(input string tag, input int n);
      chk({tag, "_count"}, 32'(nlog), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < nlog) begin
            chk({tag, "_id"}, 32'(lg_id[i]), 32'(exp_id[i]));
            chk({tag, "_data"}, 32'(lg_dt[i]), 32'(exp_dt[i]));
         end
      end
   endtask

   initial begin : main
      int c0, len;
      bit nolast;
      n_chk     = 0;
      n_err     = 0;
      cyc       = 0;
      rst_n     = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      tx_ready  = 1'b0;
      tr        = 1'b1;
      obs_tv    = 1'b0;
      obs_td    = 8'h00;
      obs_busy  = 1'b0;
      obs_gid   = 2'd0;
      obs_rdy   = 4'h0;
      clear_streams();
      model_reset();
      #2;
      do_reset("init");
      tr = 1'b1;

      // single stream from requester 2
      push(2, 8'h41, 0);
      push(2, 8'h42, 0);
      push(2, 8'h43, 1);
      c0 = cyc + 1;
      repeat (6) step();
      set_exp(0, 2, 'h41);
      set_exp(1, 2, 'h42);
      set_exp(2, 2, 'h43);
      cmp_log("single", 3);
      for (int i = 0; i < 3; i++) begin
         if (i < nlog) chk("single_cycle", 32'(lg_cyc[i]), 32'(c0 + 1 + i));
      end
      chk("single_busy_after", 32'(obs_busy), 32'd0);
      chk("model_rr_after_single", 32'(m_rr), 32'd3);

      // rr_ptr is now 3: requester 3 must win over requester 0
      clear_streams();
      push(0, 8'h10, 1);
      push(3, 8'h30, 1);
      repeat (6) step();
      set_exp(0, 3, 'h30);
      set_exp(1, 0, 'h10);
      cmp_log("rr_after_single", 2);

      // contention from reset
      do_reset("cont");
      tr = 1'b1;
      push(0, 8'hA0, 0);
      push(0, 8'hA1, 1);
      push(1, 8'hB0, 0);
      push(1, 8'hB1, 1);
      push(3, 8'hD0, 0);
      push(3, 8'hD1, 1);
      c0 = cyc + 1;
      repeat (12) step();
      set_exp(0, 0, 'hA0);
      set_exp(1, 0, 'hA1);
      set_exp(2, 1, 'hB0);
      set_exp(3, 1, 'hB1);
      set_exp(4, 3, 'hD0);
      set_exp(5, 3, 'hD1);
      cmp_log("cont", 6);
      if (nlog >= 6) begin
         chk("cont_first", 32'(lg_cyc[0]), 32'(c0 + 1));
         chk("cont_pkt0", 32'(lg_cyc[1] - lg_cyc[0]), 32'd1);
         chk("cont_gap01", 32'(lg_cyc[2] - lg_cyc[1]), 32'd2);
         chk("cont_gap13", 32'(lg_cyc[4] - lg_cyc[3]), 32'd2);
      end

      // burst cap: req 1 cut after 4 bytes, req 2 served, req 1 resumes
      clear_streams();
      for (int i = 0; i < 6; i++) push(1, 8'(8'h11 + i), 0);
      push(2, 8'h20, 1);
      repeat (22) step();
      for (int i = 0; i < 4; i++) set_exp(i, 1, 'h11 + i);
      set_exp(4, 2, 'h20);
      set_exp(5, 1, 'h15);
      set_exp(6, 1, 'h16);
      cmp_log("burst", 7);

      // back-pressure mid-packet
      clear_streams();
      push(0, 8'h50, 0);
      push(0, 8'h51, 0);
      push(0, 8'h52, 1);
      step();
      step();
      tr = 1'b0;
      repeat (10) begin
         step();
         chk("bp_valid", 32'(obs_tv), 32'd1);
         chk("bp_data", 32'(obs_td), 32'h51);
         chk("bp_ready", 32'(obs_rdy), 32'd0);
      end
      tr = 1'b1;
      repeat (5) step();
      set_exp(0, 0, 'h50);
      set_exp(1, 0, 'h51);
      set_exp(2, 0, 'h52);
      cmp_log("bp", 3);

      // idle timeout: req 1 drops valid after one byte, req 2 waits
      clear_streams();
      push(1, 8'h60, 0);
      push(1, 8'h61, 1);
      push(2, 8'h70, 1);
      step();
      step();
      chk("to_first_byte", 32'(obs_td), 32'h60);
      gate[1] = 1'b0;
      repeat (IDLT) begin
         step();
         chk("to_busy_hold", 32'(obs_busy), 32'd1);
      end
      step();
      chk("to_busy_fall", 32'(obs_busy), 32'd0);
      step();
      chk("to_next_grant", 32'(obs_gid), 32'd2);
      chk("to_next_valid", 32'(obs_tv), 32'd1);
      chk("to_next_data", 32'(obs_td), 32'h70);
      gate[1] = 1'b1;
      repeat (6) step();

      // async reset between bytes of a packet from req 3
      clear_streams();
      push(3, 8'h80, 0);
      push(3, 8'h81, 0);
      push(3, 8'h82, 1);
      step();
      step();
      chk("pre_rst_valid", 32'(obs_tv), 32'd1);
      do_reset("mid");
      tr = 1'b1;
      push(3, 8'h90, 0);
      push(3, 8'h91, 1);
      c0 = cyc + 1;
      repeat (6) step();
      set_exp(0, 3, 'h90);
      set_exp(1, 3, 'h91);
      cmp_log("post_rst", 2);
      if (nlog >= 1) chk("post_rst_cycle", 32'(lg_cyc[0]), 32'(c0 + 1));

      // random traffic
      clear_streams();
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 15) == 0 && tail[i] - head[i] < 6 &&
                tail[i] < CAP - 8) begin
               len    = int'($urandom_range(1, 5));
               nolast = ($urandom_range(0, 7) == 0);
               for (int b = 0; b < len; b++) begin
                  push(i, 8'($urandom), (b == len - 1) && !nolast);
               end
            end
            if ($urandom_range(0, 9) == 0) gate[i] = !gate[i];
         end
         tr = ($urandom_range(0, 3) != 0);
         step();
      end
      for (int i = 0; i < N; i++) gate[i] = 1'b1;
      tr = 1'b1;
      repeat (400) step();
      for (int i = 0; i < N; i++) begin
         chk("rand_all_bytes_out", 32'(obs_idx[i]), 32'(tail[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
